// File: rtl/ofifo_col_collector_pkg.sv
// Shared constants for the column output collector.
// Optional build macro used elsewhere: OFIFO_RELU_EN (clamp negative psums at the out register).
package ofifo_col_collector_pkg;

    localparam int COL         = 8;
    localparam int PSUM_BW     = 16;
    localparam int OFIFO_DEPTH = 64;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/ofifo_col_fifo.sv
// Single-column synchronous FIFO; dout shows the entry at rd_ptr combinationally.
// rd must only be asserted when the FIFO is non-empty (the collector guarantees this).
module ofifo_col_fifo
    import ofifo_col_collector_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = OFIFO_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic               rd,
    input  logic [psum_bw-1:0] din,
    output logic [psum_bw-1:0] dout,
    output logic               empty,
    output logic               full,
    output logic               overflow
);

    localparam int AW = ptr_w(depth);

    logic [psum_bw-1:0] mem [depth];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic               wr_acc;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(depth));
    // A full column still takes a write when a read frees a slot in the same cycle.
    assign wr_acc   = wr && (!full || rd);
    assign overflow = wr && full && !rd;
    assign dout     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset && wr_acc)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr_acc, rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ofifo_col_collector.sv
// Per-column FIFOs feeding one row-aligned, registered read port.
// Build macro OFIFO_RELU_EN clamps negative psums to zero at the out register.
module ofifo_col_collector
    import ofifo_col_collector_pkg::*;
#(
    parameter int col     = COL,
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = OFIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col-1:0]         wr,
    input  logic [col*psum_bw-1:0] in,
    input  logic                   rd,
    output logic [col*psum_bw-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_overflow,
    output logic                   o_rd_done
);

    logic [col-1:0]         empty;
    logic [col-1:0]         full;
    logic [col-1:0]         ovf;
    logic [col*psum_bw-1:0] row;
    logic [col*psum_bw-1:0] row_next;
    logic                   rd_acc;

    assign o_valid = ~|empty;
    assign o_full  = |full;
    assign o_ready = ~o_full;
    assign rd_acc  = rd && o_valid;

    for (genvar i = 0; i < col; i++) begin : g_col
        ofifo_col_fifo #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .wr       (wr[i]),
            .rd       (rd_acc),
            .din      (in[i*psum_bw +: psum_bw]),
            .dout     (row[i*psum_bw +: psum_bw]),
            .empty    (empty[i]),
            .full     (full[i]),
            .overflow (ovf[i])
        );
    end

    always_comb begin
        row_next = row;
`ifdef OFIFO_RELU_EN
        for (int i = 0; i < col; i++) begin
            if (row[i*psum_bw + psum_bw - 1])
                row_next[i*psum_bw +: psum_bw] = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out        <= '0;
            o_rd_done  <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            if (rd_acc)
                out <= row_next;
            o_rd_done <= rd_acc;
            if (|ovf)
                o_overflow <= 1'b1;
        end
    end

endmodule

// File: doc/ofifo_col_collector.md
Name: ofifo_col_collector

Overview:
- Downstream collector for the systolic MAC array. Captures partial sums as they drain from the south edge of each array column (out_s of the bottom-row tiles) in either WS or OS-flush mode.
- Columns produce results skewed in time. The block holds one FIFO per column and releases a full row only when every column has at least one entry.
- It feeds the SRAM write-back / SFU path with one aligned row per read.

Parameters:
- col, 8, number of array columns (one FIFO per column)
- psum_bw, 16, width of one partial sum
- depth, 64, entries per column FIFO; must be a power of 2, minimum 2

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- wr  input  col  per-column write strobe; bit i qualifies column i of in
- in  input  col*psum_bw  column psums; column i occupies bits [psum_bw*(i+1)-1 : psum_bw*i]
- rd  input  1  row read request
- out  output  col*psum_bw  registered row of psums, column i in the same bit slice as in
- o_valid  output  1  every column FIFO is non-empty, so a row can be read
- o_full  output  1  at least one column FIFO is full
- o_ready  output  1  no column FIFO is full, so all columns can accept a write
- o_overflow  output  1  sticky flag: a write was dropped on a full column
- o_rd_done  output  1  pulses one cycle after an accepted read, when out holds the new row

Behaviour:
- Reset values:
  - all pointers and counts = 0
  - out = 0, o_valid = 0, o_full = 0, o_ready = 1, o_overflow = 0, o_rd_done = 0
- Reset mid-operation discards all stored data. There are no write or read side effects in the reset cycle.
- Per-column storage:
  - wr_ptr and rd_ptr are each log2(depth) bits and wrap modulo depth.
  - count is log2(depth)+1 bits.
  - empty = (count == 0); full = (count == depth).
- Write, column i:
  - if wr[i] and column i is not full, store in slice i at wr_ptr; wr_ptr+1; count+1.
  - if wr[i] and column i is full, drop the data and set o_overflow. o_overflow clears only on reset.
- Read:
  - Accepted only when rd and o_valid are both 1 in the same cycle. All columns advance rd_ptr together and each count decrements.
  - rd while o_valid = 0 is ignored: no pointer change, out holds its value.
- Read latency is 1 cycle. The row at the rd_ptrs is registered into out on the accepting edge. o_rd_done = 1 for exactly the following cycle.
- Simultaneous write and accepted read on the same column:
  - count is unchanged.
  - A write to a full column is accepted if a read is accepted in the same cycle.
- o_valid, o_full and o_ready are derived from the registered counts only. A write into an empty column does not raise o_valid until the next cycle; there is no fall-through.
- Columns fill independently, so skew between columns is tolerated up to depth entries.
- No arithmetic is performed on data. psum_bw bits pass through unmodified, except as described under Optional Feature.

Optional Feature:
- Macro OFIFO_RELU_EN.
- Defined: each psum_bw slice is clamped at the out register input. A negative value (MSB = 1, two's complement) becomes 0; other values pass unchanged. Storage is unaffected and latency is unchanged.
- Not defined: out carries the stored values verbatim.

Decomposition:
- Shared package: constants COL = 8, PSUM_BW = 16, OFIFO_DEPTH = 64, plus a helper for the pointer width log2(depth).
- One natural sub-module: ofifo_col_fifo.
  - Contents: single-column synchronous FIFO, parameters psum_bw and depth.
  - Ports: wr, rd, din, dout (combinational at rd_ptr), empty, full, overflow pulse.
  - The top instantiates col copies and owns the row-aligned read, the out register, o_rd_done, sticky overflow and the ReLU clamp.

Test Plan:
- Skewed fill:
  - Stimulus: write column i with value 0x0010+i starting at cycle i, for i = 0..7.
  - Response: o_valid stays 0 until the cycle after column 7 is written. Then rd gives out slices 0x0010..0x0017, with o_rd_done high one cycle later.
- Empty read:
  - Stimulus: after reset, assert rd for 5 cycles with no writes.
  - Response: out stays 0, o_rd_done stays 0, pointers unchanged.
- Full / overflow:
  - Stimulus: write column 3 65 times (values 1..65) with no reads.
  - Response: o_full = 1 and o_ready = 0 after the 64th write. o_overflow = 1 after the 65th. Value 65 is not stored.
- Simultaneous read/write at full:
  - Stimulus: all columns full, o_valid = 1; assert rd and wr = 8'hFF with value 0x0AAA.
  - Response: write accepted, counts stay 64, o_overflow stays 0, out = the oldest row.
- Wrap-around:
  - Stimulus: stream 200 rows with rd and wr both active, row n = n.
  - Response: outputs come out in order 0..199 with no loss across pointer wrap.
- Reset mid-stream plus ReLU:
  - Stimulus: after 10 writes per column, pulse reset. Then with OFIFO_RELU_EN defined, write 0xFFF0 to all columns and read.
  - Response: after reset, o_valid = 0 and out = 0. The read returns out = 0 in every slice; without the macro it returns 0xFFF0.
